funrv32_regfile_bist: RTL and testbench
=======================================

// Module: funrv32_regfile_bist
//
// PURPOSE
// Self-checking built-in test sequencer for the funRV32 register file.
// Drives the regfile's write port and both read ports, writes a
// pass-dependent pattern to every register, reads it back on both ports
// and compares. Reports pass/fail, an error count and the first failing
// address. Sits beside the regfile in test tops; replaces free-running
// counter exercisers.
//
// PARAMETERS
// XLEN      32  data width of regfile entries
// ADDR_W     5  address width; DEPTH = 2**ADDR_W registers
// NPASS      2  number of write/read passes (>=1)
// READ_LAT   0  regfile read latency in cycles (0 = combinational, 1 = registered)
// ZERO_REG   1  1: register 0 is hardwired to zero, so its expected read value is 0
// ERR_W      8  width of the saturating error counter
//
// PORTS
// clk             in   1       clock, all state updates on posedge
// reset           in   1       synchronous, active-high
// start           in   1       launch the test; sampled only in IDLE or DONE
// busy            out  1       high in WRITE, READ and DRAIN
// done            out  1       high in DONE; stays high until start or reset
// pass_ok         out  1       valid when done: 1 iff err_count==0
// err_count       out  ERR_W   mismatch count, saturates at all-ones
// first_err_valid out  1       set on the first mismatch, then sticky
// first_err_addr  out  ADDR_W  address of the first mismatch
// first_err_port  out  1       port of the first mismatch: 0 = r1, 1 = r2
// rf_we           out  1       regfile write enable
// rf_ad           out  ADDR_W  regfile write address
// rf_wd           out  XLEN    regfile write data
// rf_a1, rf_a2    out  ADDR_W  regfile read addresses
// rf_r1, rf_r2    in   XLEN    regfile read data
//
// BEHAVIOUR
// - Reset: state goes to IDLE. All outputs and counters are 0, including
//   rf_we=0. Reset in the middle of a run aborts it immediately.
// - Pattern: D(a,p) = zext(a) + p, computed mod 2**XLEN.
//     Odd passes use the inverted value: exp(a,p) = p[0] ? ~D : D.
//     If ZERO_REG=1, the expected read value of register 0 is always 0.
//     Writes to register 0 are still issued.
// - FSM:
//     IDLE  --start-->  WRITE; clears all counters and flags, p=0.
//     WRITE  DEPTH cycles. rf_we=1; rf_ad goes 0..DEPTH-1; rf_wd=exp-before-zero-override.
//            Then go to READ.
//     READ   DEPTH cycles. rf_we=0; rf_a1 = i (0..DEPTH-1); rf_a2 = DEPTH-1-i.
//            Then go to DRAIN, or if READ_LAT=0, go straight to the pass end.
//     DRAIN  READ_LAT cycles, flushing the compare pipeline.
//     Pass end: if p < NPASS-1, set p++ and go to WRITE; otherwise go to DONE.
//     DONE  --start-->  behaves exactly as start from IDLE.
// - start while busy is ignored.
// - Compare timing: the expected values and addresses for read cycle i are
//   delayed by READ_LAT. rf_r1 and rf_r2 are compared in that later cycle.
//   Both ports are checked every read cycle.
// - Counting: a mismatch on both ports in the same cycle adds 2, still
//   saturating. If both ports mismatch in the first failing cycle, port 0
//   is recorded as first_err.
// - Latency: start is sampled at edge t. done rises at edge
//   t + NPASS*(2*DEPTH+READ_LAT).
// - busy and done are never high together. pass_ok=0 whenever done=0.
//
// TESTING
// 1. Defaults, ideal comb. regfile, start pulse -> done after 128 cycles;
//    err_count=0, pass_ok=1, first_err_valid=0.
// 2. Regfile model with reg 7 bit 5 stuck at 1
//    -> err_count=2 (pass 0 only, via ports r1 and r2);
//    first_err_addr=7, first_err_port=0, pass_ok=0.
// 3. ZERO_REG=1 with a model that really stores reg 0
//    -> pass 1 reads ~1 on both ports; err_count=2, first_err_addr=0.
// 4. ERR_W=2, model whose read ports always return 0 -> err_count=3 (saturated).
// 5. READ_LAT=1, registered-read model -> done after 130 cycles, err_count=0.
// 6. Reset asserted in cycle 10 of WRITE -> next cycle busy=0, rf_we=0,
//    counters 0. A new start then gives the scenario 1 result.

Source files
------------

// File: rtl/funrv32_regfile_bist_if.sv
// Register-file access bus between the BIST sequencer (master) and the regfile (slave).
// One write port and two combinational or registered read ports.
interface funrv32_regfile_bist_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              rf_we;
    logic [ADDR_W-1:0] rf_ad;
    logic [XLEN-1:0]   rf_wd;
    logic [ADDR_W-1:0] rf_a1;
    logic [ADDR_W-1:0] rf_a2;
    logic [XLEN-1:0]   rf_r1;
    logic [XLEN-1:0]   rf_r2;

    modport master (
        output rf_we, rf_ad, rf_wd, rf_a1, rf_a2,
        input  rf_r1, rf_r2
    );

    modport slave (
        input  rf_we, rf_ad, rf_wd, rf_a1, rf_a2,
        output rf_r1, rf_r2
    );
endinterface

// File: rtl/funrv32_regfile_bist.sv
// Built-in self test for the funRV32 register file: writes a pass-dependent pattern
// to every entry, reads it back on both ports and records mismatches.
module funrv32_regfile_bist #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NPASS    = 2,
    parameter int READ_LAT = 0,
    parameter int ZERO_REG = 1,
    parameter int ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass_ok,
    output logic [ERR_W-1:0]      err_count,
    output logic                  first_err_valid,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic                  first_err_port,
    funrv32_regfile_bist_if.master rf
);

    localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int DR_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int SUM_W  = ERR_W + 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NPASS - 1);
    localparam logic [PASS_W-1:0] PASS_ONE  = 1;
    localparam logic [DR_W-1:0]   LAST_DR   = DR_W'(READ_LAT - 1);
    localparam logic [DR_W-1:0]   DR_ONE    = 1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [PASS_W-1:0] pass;
    logic [DR_W-1:0]   drain_cnt;

    // Write data before the register-0 override; odd passes store the inverted value.
    function automatic logic [XLEN-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [PASS_W-1:0] p);
        logic [XLEN-1:0] d;
        d = XLEN'(a) + XLEN'(p);
        return p[0] ? ~d : d;
    endfunction

    function automatic logic [XLEN-1:0] expected(input logic [ADDR_W-1:0] a,
                                                 input logic [PASS_W-1:0] p);
        if (ZERO_REG != 0 && a == '0)
            return '0;
        return pattern(a, p);
    endfunction

    logic              s0_valid;
    logic [XLEN-1:0]   s0_e1, s0_e2;
    logic              c_valid;
    logic [ADDR_W-1:0] c_a1, c_a2;
    logic [XLEN-1:0]   c_e1, c_e2;

    assign s0_valid = (state == READ);
    assign s0_e1    = expected(rf.rf_a1, pass);
    assign s0_e2    = expected(rf.rf_a2, pass);

    // Expected values travel alongside the regfile's read latency so they meet the data.
    generate
        if (READ_LAT == 0) begin : g_comb
            assign c_valid = s0_valid;
            assign c_a1    = rf.rf_a1;
            assign c_a2    = rf.rf_a2;
            assign c_e1    = s0_e1;
            assign c_e2    = s0_e2;
        end else begin : g_pipe
            logic              pv  [READ_LAT];
            logic [ADDR_W-1:0] pa1 [READ_LAT];
            logic [ADDR_W-1:0] pa2 [READ_LAT];
            logic [XLEN-1:0]   pe1 [READ_LAT];
            logic [XLEN-1:0]   pe2 [READ_LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < READ_LAT; k++) begin
                        pv[k]  <= 1'b0;
                        pa1[k] <= '0;
                        pa2[k] <= '0;
                        pe1[k] <= '0;
                        pe2[k] <= '0;
                    end
                end else begin
                    pv[0]  <= s0_valid;
                    pa1[0] <= rf.rf_a1;
                    pa2[0] <= rf.rf_a2;
                    pe1[0] <= s0_e1;
                    pe2[0] <= s0_e2;
                    for (int k = 1; k < READ_LAT; k++) begin
                        pv[k]  <= pv[k-1];
                        pa1[k] <= pa1[k-1];
                        pa2[k] <= pa2[k-1];
                        pe1[k] <= pe1[k-1];
                        pe2[k] <= pe2[k-1];
                    end
                end
            end

            assign c_valid = pv[READ_LAT-1];
            assign c_a1    = pa1[READ_LAT-1];
            assign c_a2    = pa2[READ_LAT-1];
            assign c_e1    = pe1[READ_LAT-1];
            assign c_e2    = pe2[READ_LAT-1];
        end
    endgenerate

    logic             mis1, mis2;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_next;
    logic             pass_end;

    always_comb begin
        mis1     = c_valid && (rf.rf_r1 != c_e1);
        mis2     = c_valid && (rf.rf_r2 != c_e2);
        err_sum  = SUM_W'(err_count) + SUM_W'(mis1) + SUM_W'(mis2);
        err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
        pass_end = ((state == READ) && (rf.rf_a1 == LAST_ADDR) && (READ_LAT == 0)) ||
                   ((state == DRAIN) && (drain_cnt == LAST_DR));
    end

    // Sequencer; the pass-end override at the bottom wins over the per-state moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pass            <= '0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass_ok         <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_port  <= 1'b0;
            rf.rf_we        <= 1'b0;
            rf.rf_ad        <= '0;
            rf.rf_wd        <= '0;
            rf.rf_a1        <= '0;
            rf.rf_a2        <= '0;
        end else begin
            err_count <= err_next;
            if (!first_err_valid && (mis1 || mis2)) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= mis1 ? c_a1 : c_a2;
                first_err_port  <= !mis1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= WRITE;
                        pass            <= '0;
                        drain_cnt       <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass_ok         <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                        first_err_port  <= 1'b0;
                        rf.rf_we        <= 1'b1;
                        rf.rf_ad        <= '0;
                        rf.rf_wd        <= pattern('0, '0);
                    end
                end
                WRITE: begin
                    if (rf.rf_ad == LAST_ADDR) begin
                        state    <= READ;
                        rf.rf_we <= 1'b0;
                        rf.rf_ad <= '0;
                        rf.rf_wd <= '0;
                        rf.rf_a1 <= '0;
                        rf.rf_a2 <= LAST_ADDR;
                    end else begin
                        rf.rf_ad <= rf.rf_ad + ADDR_ONE;
                        rf.rf_wd <= pattern(rf.rf_ad + ADDR_ONE, pass);
                    end
                end
                READ: begin
                    if (rf.rf_a1 == LAST_ADDR) begin
                        rf.rf_a1  <= '0;
                        rf.rf_a2  <= '0;
                        drain_cnt <= '0;
                        if (READ_LAT != 0)
                            state <= DRAIN;
                    end else begin
                        rf.rf_a1 <= rf.rf_a1 + ADDR_ONE;
                        rf.rf_a2 <= rf.rf_a2 - ADDR_ONE;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DR_ONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (pass_end) begin
                if (pass == LAST_PASS) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass_ok <= (err_next == '0);
                end else begin
                    state    <= WRITE;
                    pass     <= pass + PASS_ONE;
                    rf.rf_we <= 1'b1;
                    rf.rf_ad <= '0;
                    rf.rf_wd <= pattern('0, pass + PASS_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_funrv32_regfile_bist.sv
// Self-checking bench for funrv32_regfile_bist: three instances (default, 2-bit error
// counter, registered-read regfile) each paired with a behavioural regfile model.
module tb_funrv32_regfile_bist;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    always #5 clk = ~clk;

    funrv32_regfile_bist_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_a ();
    funrv32_regfile_bist_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_b ();
    funrv32_regfile_bist_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_c ();

    logic busy_a, done_a, ok_a, fv_a, fp_a;
    logic busy_b, done_b, ok_b, fv_b, fp_b;
    logic busy_c, done_c, ok_c, fv_c, fp_c;
    logic [7:0] err_a, err_c;
    logic [1:0] err_b;
    logic [ADDR_W-1:0] fa_a, fa_b, fa_c;

    funrv32_regfile_bist #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NPASS(2), .READ_LAT(0),
                           .ZERO_REG(1), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .pass_ok(ok_a), .err_count(err_a), .first_err_valid(fv_a),
        .first_err_addr(fa_a), .first_err_port(fp_a), .rf(bus_a)
    );

    funrv32_regfile_bist #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NPASS(2), .READ_LAT(0),
                           .ZERO_REG(1), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .pass_ok(ok_b), .err_count(err_b), .first_err_valid(fv_b),
        .first_err_addr(fa_b), .first_err_port(fp_b), .rf(bus_b)
    );

    funrv32_regfile_bist #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NPASS(2), .READ_LAT(1),
                           .ZERO_REG(1), .ERR_W(8)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .pass_ok(ok_c), .err_count(err_c), .first_err_valid(fv_c),
        .first_err_addr(fa_c), .first_err_port(fp_c), .rf(bus_c)
    );

    // Model A: mode 0 ideal, 1 reg 7 bit 5 stuck at 1, 2 reg 0 really stored.
    logic [XLEN-1:0] mem_a [DEPTH];
    logic [XLEN-1:0] mem_c [DEPTH];
    logic [1:0]      model_mode = 2'd0;

    always_ff @(posedge clk) begin
        if (bus_a.rf_we) mem_a[bus_a.rf_ad] <= bus_a.rf_wd;
        if (bus_c.rf_we) mem_c[bus_c.rf_ad] <= bus_c.rf_wd;
        bus_c.rf_r1 <= (bus_c.rf_a1 == '0) ? '0 : mem_c[bus_c.rf_a1];
        bus_c.rf_r2 <= (bus_c.rf_a2 == '0) ? '0 : mem_c[bus_c.rf_a2];
    end

    always_comb begin
        bus_a.rf_r1 = mem_a[bus_a.rf_a1];
        bus_a.rf_r2 = mem_a[bus_a.rf_a2];
        if (model_mode != 2'd2) begin
            if (bus_a.rf_a1 == '0) bus_a.rf_r1 = '0;
            if (bus_a.rf_a2 == '0) bus_a.rf_r2 = '0;
        end
        if (model_mode == 2'd1) begin
            if (bus_a.rf_a1 == 5'd7) bus_a.rf_r1[5] = 1'b1;
            if (bus_a.rf_a2 == 5'd7) bus_a.rf_r2[5] = 1'b1;
        end
    end

    assign bus_b.rf_r1 = '0;
    assign bus_b.rf_r2 = '0;

    int cur_sel = 0;
    logic cur_busy, cur_done, cur_ok, cur_fv, cur_fp, cur_we;
    logic [7:0] cur_err;
    logic [ADDR_W-1:0] cur_fa, cur_ad, cur_a1, cur_a2;
    logic [XLEN-1:0] cur_wd;

    always_comb begin
        case (cur_sel)
            1: begin
                {cur_busy, cur_done, cur_ok, cur_fv, cur_fp} = {busy_b, done_b, ok_b, fv_b, fp_b};
                cur_err = {6'd0, err_b};
                cur_fa  = fa_b;
                {cur_we, cur_ad, cur_wd, cur_a1, cur_a2} =
                    {bus_b.rf_we, bus_b.rf_ad, bus_b.rf_wd, bus_b.rf_a1, bus_b.rf_a2};
            end
            2: begin
                {cur_busy, cur_done, cur_ok, cur_fv, cur_fp} = {busy_c, done_c, ok_c, fv_c, fp_c};
                cur_err = err_c;
                cur_fa  = fa_c;
                {cur_we, cur_ad, cur_wd, cur_a1, cur_a2} =
                    {bus_c.rf_we, bus_c.rf_ad, bus_c.rf_wd, bus_c.rf_a1, bus_c.rf_a2};
            end
            default: begin
                {cur_busy, cur_done, cur_ok, cur_fv, cur_fp} = {busy_a, done_a, ok_a, fv_a, fp_a};
                cur_err = err_a;
                cur_fa  = fa_a;
                {cur_we, cur_ad, cur_wd, cur_a1, cur_a2} =
                    {bus_a.rf_we, bus_a.rf_ad, bus_a.rf_wd, bus_a.rf_a1, bus_a.rf_a2};
            end
        endcase
    end

    typedef struct {
        int sel;
        int mode;
        int lat;
        int err;
        bit ok;
        bit fv;
        int fa;
        int fp;
        int restart_at;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [XLEN-1:0] pat(input int a, input int p);
        logic [XLEN-1:0] d;
        d = XLEN'(a + p);
        return (p % 2 == 1) ? ~d : d;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setStart(input int sel, input logic val);
        case (sel)
            1: start_b = val;
            2: start_c = val;
            default: start_a = val;
        endcase
    endtask

    task automatic checkBus(input int idx, input int per_pass);
        int p, w;
        p = idx / per_pass;
        w = idx % per_pass;
        if (w < DEPTH)
            compare("write_bus", {cur_busy, cur_done, cur_we, cur_ad, cur_wd},
                    {1'b1, 1'b0, 1'b1, 5'(w), pat(w, p)});
        else if (w < 2 * DEPTH)
            compare("read_bus", {cur_busy, cur_done, cur_we, cur_a1, cur_a2},
                    {1'b1, 1'b0, 1'b0, 5'(w - DEPTH), 5'(2 * DEPTH - 1 - w)});
        else
            compare("drain_bus", {cur_busy, cur_done, cur_we}, {1'b1, 1'b0, 1'b0});
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_q.push_back(v);
        cur_sel    = v.sel;
        model_mode = 2'(v.mode);
        @(negedge clk);
        setStart(v.sel, 1'b1);
        @(posedge clk);
        #1;
        setStart(v.sel, 1'b0);
    endtask

    task automatic checkOutput();
        vec_t v;
        int idx, per_pass;
        v = sb_q.pop_front();
        per_pass = 2 * DEPTH + ((v.sel == 2) ? 1 : 0);
        idx = 0;
        while (idx < 1000 && !cur_done) begin
            checkBus(idx, per_pass);
            if (idx == v.restart_at) setStart(v.sel, 1'b1);
            @(posedge clk);
            #1;
            setStart(v.sel, 1'b0);
            idx++;
        end
        compare("done_latency", 64'(idx), 64'(v.lat));
        compare("busy_done", {cur_busy, cur_done}, 2'b01);
        compare("err_count", 64'(cur_err), 64'(v.err));
        compare("pass_ok", cur_ok, v.ok);
        compare("first_err", {cur_fv, cur_fa, cur_fp}, {v.fv, 5'(v.fa), 1'(v.fp)});
        repeat (3) @(posedge clk);
        #1;
        compare("done_held", {cur_busy, cur_done, cur_ok}, {1'b0, 1'b1, v.ok});
    endtask

    // Start on instance A, stop at run cycle stop_idx, then reset and expect a clean IDLE.
    task automatic abortRun(input int mode, input int stop_idx, input int exp_err,
                            input bit exp_fv, input int exp_fa);
        cur_sel    = 0;
        model_mode = 2'(mode);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int i = 0; i < stop_idx; i++) begin
            @(posedge clk);
            #1;
        end
        compare("pre_abort", {cur_busy, cur_err, cur_fv, cur_fa},
                {1'b1, 8'(exp_err), exp_fv, 5'(exp_fa)});
        reset = 1'b1;
        @(posedge clk);
        #1;
        compare("abort_state", {cur_busy, cur_done, cur_ok, cur_we, cur_err, cur_fv, cur_fa, cur_fp}, 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{sel: 0, mode: 0, lat: 128, err: 0, ok: 1, fv: 0, fa: 0,  fp: 0, restart_at: -1};
        vecs[1] = '{sel: 0, mode: 1, lat: 128, err: 2, ok: 0, fv: 1, fa: 7,  fp: 0, restart_at: -1};
        vecs[2] = '{sel: 0, mode: 2, lat: 128, err: 2, ok: 0, fv: 1, fa: 0,  fp: 0, restart_at: -1};
        vecs[3] = '{sel: 1, mode: 0, lat: 128, err: 3, ok: 0, fv: 1, fa: 31, fp: 1, restart_at: -1};
        vecs[4] = '{sel: 2, mode: 0, lat: 130, err: 0, ok: 1, fv: 0, fa: 0,  fp: 0, restart_at: -1};
        vecs[5] = '{sel: 0, mode: 0, lat: 128, err: 0, ok: 1, fv: 0, fa: 0,  fp: 0, restart_at: 40};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            cur_sel = s;
            #1;
            compare("reset_state", {cur_busy, cur_done, cur_ok, cur_we, cur_err, cur_fv, cur_fa, cur_fp}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        abortRun(0, 10, 0, 1'b0, 0);
        abortRun(1, 52, 1, 1'b1, 7);
        applyStimulus(vecs[0]);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
